// File: rtl/oc8051_alu_seq.sv
// Sequencer wrapped around the oc8051 ALU. It accepts one request, holds the operands
// steady while the ALU computes, and registers the results, a timeout flag and the PSW flags.
module oc8051_alu_seq #(
    parameter int unsigned MAX_WAIT = 32
) (
    input  logic       clk,
    input  logic       rst,
    // request side
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [7:0] req_src1,
    input  logic [7:0] req_src2,
    input  logic [7:0] req_src3,
    input  logic       req_bit,
    input  logic [2:0] req_psw_we,
    // ALU side
    output logic [3:0] alu_op,
    output logic [7:0] alu_src1,
    output logic [7:0] alu_src2,
    output logic [7:0] alu_src3,
    output logic       alu_cy,
    output logic       alu_ac,
    output logic       alu_bit,
    output logic       alu_valid,
    input  logic [7:0] alu_des_acc,
    input  logic [7:0] alu_des1,
    input  logic [7:0] alu_des2,
    input  logic       alu_cy_o,
    input  logic       alu_ac_o,
    input  logic       alu_ov_o,
    input  logic       alu_valid_o,
    // result side
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_acc,
    output logic [7:0] res_des1,
    output logic [7:0] res_des2,
    output logic       res_err,
    output logic       psw_cy,
    output logic       psw_ac,
    output logic       psw_ov
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_e;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [3:0] op_q, op_d;
    logic [7:0] src1_q, src1_d;
    logic [7:0] src2_q, src2_d;
    logic [7:0] src3_q, src3_d;
    logic       bit_q, bit_d;
    logic [2:0] psw_we_q, psw_we_d;
    logic [7:0] res_acc_q, res_acc_d;
    logic [7:0] res_des1_q, res_des1_d;
    logic [7:0] res_des2_q, res_des2_d;
    logic       res_err_q, res_err_d;
    logic       psw_cy_q, psw_cy_d;
    logic       psw_ac_q, psw_ac_d;
    logic       psw_ov_q, psw_ov_d;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d    = state_q;
        wait_d     = wait_q;
        op_d       = op_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        src3_d     = src3_q;
        bit_d      = bit_q;
        psw_we_d   = psw_we_q;
        res_acc_d  = res_acc_q;
        res_des1_d = res_des1_q;
        res_des2_d = res_des2_q;
        res_err_d  = res_err_q;
        psw_cy_d   = psw_cy_q;
        psw_ac_d   = psw_ac_q;
        psw_ov_d   = psw_ov_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d     = req_op;
                    src1_d   = req_src1;
                    src2_d   = req_src2;
                    src3_d   = req_src3;
                    bit_d    = req_bit;
                    psw_we_d = req_psw_we;
                    wait_d   = 8'd0;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                // A valid result wins over a timeout that falls on the same edge.
                if (alu_valid_o) begin
                    res_acc_d  = alu_des_acc;
                    res_des1_d = alu_des1;
                    res_des2_d = alu_des2;
                    res_err_d  = 1'b0;
                    if (psw_we_q[2]) psw_cy_d = alu_cy_o;
                    if (psw_we_q[1]) psw_ac_d = alu_ac_o;
                    if (psw_we_q[0]) psw_ov_d = alu_ov_o;
                    state_d    = S_DONE;
                end else if (wait_q == WAIT_LAST) begin
                    res_acc_d  = 8'h00;
                    res_des1_d = 8'h00;
                    res_des2_d = 8'h00;
                    res_err_d  = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DONE: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wait_q     <= 8'd0;
            op_q       <= 4'd0;
            src1_q     <= 8'd0;
            src2_q     <= 8'd0;
            src3_q     <= 8'd0;
            bit_q      <= 1'b0;
            psw_we_q   <= 3'd0;
            res_acc_q  <= 8'd0;
            res_des1_q <= 8'd0;
            res_des2_q <= 8'd0;
            res_err_q  <= 1'b0;
            psw_cy_q   <= 1'b0;
            psw_ac_q   <= 1'b0;
            psw_ov_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register sample the old state on the same edge.
            state_q    <= state_d;
            wait_q     <= wait_d;
            op_q       <= op_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            src3_q     <= src3_d;
            bit_q      <= bit_d;
            psw_we_q   <= psw_we_d;
            res_acc_q  <= res_acc_d;
            res_des1_q <= res_des1_d;
            res_des2_q <= res_des2_d;
            res_err_q  <= res_err_d;
            psw_cy_q   <= psw_cy_d;
            psw_ac_q   <= psw_ac_d;
            psw_ov_q   <= psw_ov_d;
        end
    end

    // req_ready is gated by rst so that every output reads 0 while reset is held.
    assign req_ready = (state_q == S_IDLE) && rst;
    assign alu_valid = (state_q == S_EXEC);
    assign res_valid = (state_q == S_DONE);

    assign alu_op    = op_q;
    assign alu_src1  = src1_q;
    assign alu_src2  = src2_q;
    assign alu_src3  = src3_q;
    assign alu_bit   = bit_q;
    assign alu_cy    = psw_cy_q;
    assign alu_ac    = psw_ac_q;

    assign res_acc   = res_acc_q;
    assign res_des1  = res_des1_q;
    assign res_des2  = res_des2_q;
    assign res_err   = res_err_q;
    assign psw_cy    = psw_cy_q;
    assign psw_ac    = psw_ac_q;
    assign psw_ov    = psw_ov_q;

endmodule

// File: tb/tb_oc8051_alu_seq.sv
// Bench for oc8051_alu_seq. A small ALU stand-in with programmable latency sits on the ALU port.
// Expected results are hand-computed in the vector table.
module tb_oc8051_alu_seq;

    localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_MUL = 4'h3, OP_DIV = 4'h4,
                           OP_AND = 4'h7, OP_XOR = 4'h8, OP_OR  = 4'h9;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_op = 4'h0;
    logic [7:0] req_src1 = 8'h00, req_src2 = 8'h00, req_src3 = 8'h00;
    logic       req_bit = 1'b0;
    logic [2:0] req_psw_we = 3'b000;
    logic [3:0] alu_op;
    logic [7:0] alu_src1, alu_src2, alu_src3;
    logic       alu_cy, alu_ac, alu_bit, alu_valid;
    logic [7:0] s_acc, s_d1, s_d2;
    logic       s_cy, s_ac, s_ov, s_valid;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_acc, res_des1, res_des2;
    logic       res_err, psw_cy, psw_ac, psw_ov;

    int n_chk  = 0;
    int n_fail = 0;
    int lat_cfg = 1;   // EXEC cycles until the stand-in ALU answers; 0 means never
    int tb_cnt  = 0;

    always #5 clk = ~clk;

    oc8051_alu_seq #(.MAX_WAIT(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2), .req_src3(req_src3),
        .req_bit(req_bit), .req_psw_we(req_psw_we),
        .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_src3(alu_src3),
        .alu_cy(alu_cy), .alu_ac(alu_ac), .alu_bit(alu_bit), .alu_valid(alu_valid),
        .alu_des_acc(s_acc), .alu_des1(s_d1), .alu_des2(s_d2),
        .alu_cy_o(s_cy), .alu_ac_o(s_ac), .alu_ov_o(s_ov), .alu_valid_o(s_valid),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_acc(res_acc), .res_des1(res_des1), .res_des2(res_des2),
        .res_err(res_err), .psw_cy(psw_cy), .psw_ac(psw_ac), .psw_ov(psw_ov)
    );

    always_ff @(posedge clk) begin
        if (!alu_valid) tb_cnt <= 0;
        else            tb_cnt <= tb_cnt + 1;
    end

    // Behavioural ALU stand-in; des1/des2 defaults are nonzero so a timeout's zeros are visible.
    always_comb begin
        logic [8:0]  t9;
        logic [15:0] t16;
        t9    = 9'd0;
        t16   = 16'd0;
        s_acc = alu_src1;
        s_d1  = ~alu_src1;
        s_d2  = alu_src2 ^ alu_src3;
        s_cy  = 1'b0;
        s_ac  = 1'b0;
        s_ov  = 1'b0;
        case (alu_op)
            OP_ADD: begin
                t9    = {1'b0, alu_src1} + {1'b0, alu_src2} + {8'd0, alu_cy};
                s_acc = t9[7:0];
                s_cy  = t9[8];
                s_ac  = ({1'b0, alu_src1[3:0]} + {1'b0, alu_src2[3:0]} + {4'd0, alu_cy}) > 5'h0F;
                s_ov  = (alu_src1[7] == alu_src2[7]) && (t9[7] != alu_src1[7]);
            end
            OP_SUB: begin
                t9    = {1'b0, alu_src1} - {1'b0, alu_src2} - {8'd0, alu_cy};
                s_acc = t9[7:0];
                s_cy  = t9[8];
                s_ac  = {1'b0, alu_src1[3:0]} < ({1'b0, alu_src2[3:0]} + {4'd0, alu_cy});
                s_ov  = (alu_src1[7] != alu_src2[7]) && (t9[7] != alu_src1[7]);
            end
            OP_MUL: begin
                t16   = alu_src1 * alu_src2;
                s_acc = t16[7:0];
                s_d1  = t16[15:8];
                s_ov  = |t16[15:8];
            end
            OP_DIV: begin
                if (alu_src2 == 8'd0) s_ov = 1'b1;
                else begin
                    s_acc = alu_src1 / alu_src2;
                    s_d1  = alu_src1 % alu_src2;
                end
            end
            OP_AND, OP_OR, OP_XOR: begin
                s_acc = (alu_op == OP_AND) ? (alu_src1 & alu_src2) :
                        (alu_op == OP_OR)  ? (alu_src1 | alu_src2) : (alu_src1 ^ alu_src2);
                s_cy  = ~alu_cy;
                s_ac  = ~alu_ac;
                s_ov  = 1'b1;
            end
            default: ;
        endcase
        s_valid = alu_valid && (lat_cfg != 0) && (tb_cnt == lat_cfg - 1);
    end

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [7:0] s1, s2, s3;
        logic       bt;
        logic [2:0] we;
        int         lat;
        logic [7:0] e_acc, e_d1, e_d2;
        logic [2:0] e_psw;   // {cy, ac, ov} after the op
        logic       e_err;
        int         e_cyc;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [3:0] op, input logic [7:0] s1, s2, s3,
                            input logic bt, input logic [2:0] we);
        int i;
        for (i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        check("req_ready_before_start", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_src1 = s1; req_src2 = s2; req_src3 = s3;
        req_bit = bt; req_psw_we = we;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_op = ~op; req_src1 = ~s1; req_src2 = ~s2; req_src3 = ~s3;
        req_bit = ~bt; req_psw_we = ~we;
    endtask

    // Counts EXEC cycles until res_valid, flagging any operand/flag movement on the ALU port.
    task automatic wait_done(input logic [3:0] op, input logic [7:0] s1, s2, s3, input logic bt,
                             input logic cy0, ac0, output int cyc, output logic moved);
        int i;
        cyc = 0;
        moved = 1'b0;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (res_valid) break;
            if (alu_valid) begin
                cyc++;
                if ({alu_op, alu_src1, alu_src2, alu_src3, alu_bit, alu_cy, alu_ac} !==
                    {op, s1, s2, s3, bt, cy0, ac0}) moved = 1'b1;
            end
        end
        check("res_valid_within_budget", {31'd0, res_valid}, 32'd1);
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("release_res_valid_low", {31'd0, res_valid}, 32'd0);
        check("release_req_ready_high", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc;
        logic moved;
        logic cy0, ac0;
        cy0 = psw_cy;
        ac0 = psw_ac;
        lat_cfg = v.lat;
        start_op(v.op, v.s1, v.s2, v.s3, v.bt, v.we);
        wait_done(v.op, v.s1, v.s2, v.s3, v.bt, cy0, ac0, cyc, moved);
        check({v.name, "_exec_cycles"}, cyc, v.e_cyc);
        check({v.name, "_alu_port_stable"}, {31'd0, moved}, 32'd0);
        check({v.name, "_res"}, {8'd0, res_acc, res_des1, res_des2}, {8'd0, v.e_acc, v.e_d1, v.e_d2});
        check({v.name, "_err"}, {31'd0, res_err}, {31'd0, v.e_err});
        check({v.name, "_psw"}, {29'd0, psw_cy, psw_ac, psw_ov}, {29'd0, v.e_psw});
        release_result();
    endtask

    initial begin
        int   cyc;
        logic moved;
        logic bad;

        //          name       op      s1     s2     s3     bit   we      lat acc    d1     d2     psw     err   cyc
        vecs[0]  = '{"add_3a_c8", OP_ADD, 8'h3A, 8'hC8, 8'h00, 1'b0, 3'b111, 1,  8'h02, 8'hC5, 8'hC8, 3'b110, 1'b0, 1};
        vecs[1]  = '{"xor_nowe",  OP_XOR, 8'h5A, 8'h0F, 8'hF0, 1'b1, 3'b000, 1,  8'h55, 8'hA5, 8'hFF, 3'b110, 1'b0, 1};
        vecs[2]  = '{"add_ov",    OP_ADD, 8'h7F, 8'h01, 8'h00, 1'b0, 3'b111, 1,  8'h81, 8'h80, 8'h01, 3'b011, 1'b0, 1};
        vecs[3]  = '{"sub_cyonly",OP_SUB, 8'h10, 8'h01, 8'h22, 1'b0, 3'b100, 1,  8'h0F, 8'hEF, 8'h23, 3'b011, 1'b0, 1};
        vecs[4]  = '{"mul_small", OP_MUL, 8'h0C, 8'h15, 8'h00, 1'b0, 3'b111, 4,  8'hFC, 8'h00, 8'h15, 3'b000, 1'b0, 4};
        vecs[5]  = '{"mul_ff",    OP_MUL, 8'hFF, 8'hFF, 8'h0F, 1'b0, 3'b001, 4,  8'h01, 8'hFE, 8'hF0, 3'b001, 1'b0, 4};
        vecs[6]  = '{"div_64_7",  OP_DIV, 8'h64, 8'h07, 8'h00, 1'b0, 3'b111, 4,  8'h0E, 8'h02, 8'h07, 3'b000, 1'b0, 4};
        vecs[7]  = '{"and_lat2",  OP_AND, 8'hF0, 8'h3C, 8'h00, 1'b1, 3'b110, 2,  8'h30, 8'h0F, 8'h3C, 3'b110, 1'b0, 2};
        vecs[8]  = '{"timeout",   OP_DIV, 8'h55, 8'h03, 8'h11, 1'b0, 3'b111, 0,  8'h00, 8'h00, 8'h00, 3'b110, 1'b1, 32};
        vecs[9]  = '{"add_cyin",  OP_ADD, 8'h00, 8'h00, 8'h00, 1'b0, 3'b010, 1,  8'h01, 8'hFF, 8'h00, 3'b100, 1'b0, 1};
        vecs[10] = '{"valid_last",OP_ADD, 8'h01, 8'h01, 8'h00, 1'b0, 3'b111, 32, 8'h03, 8'hFE, 8'h01, 3'b000, 1'b0, 32};

        repeat (2) @(negedge clk);
        check("reset_outputs_zero",
              {req_ready, alu_valid, res_valid, res_err, psw_cy, psw_ac, psw_ov, alu_op, res_acc},
              20'd0);
        rst = 1'b1;
        #1;
        check("req_ready_after_reset", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Result held under back-pressure while a second request waits.
        lat_cfg = 1;
        start_op(OP_ADD, 8'h11, 8'h22, 8'h00, 1'b0, 3'b000);
        wait_done(OP_ADD, 8'h11, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0, cyc, moved);
        req_valid = 1'b1; req_op = OP_XOR; req_src1 = 8'h0F; req_src2 = 8'hF0; req_src3 = 8'h00;
        req_bit = 1'b0; req_psw_we = 3'b000;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if ({res_valid, req_ready, res_acc, res_des1, res_des2, res_err} !==
                {1'b1, 1'b0, 8'h33, 8'hEE, 8'h22, 1'b0}) bad = 1'b1;
        end
        check("backpressure_hold", {31'd0, bad}, 32'd0);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("backpressure_idle_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("second_req_accepted", {23'd0, alu_valid, alu_src1}, {23'd0, 1'b1, 8'h0F});
        wait_done(OP_XOR, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, cyc, moved);
        check("second_req_result", {24'd0, res_acc}, 32'h0000_00FF);
        release_result();

        // Reset pulsed in the middle of a DIV after PSW has been made nonzero.
        run_vec('{"add_80_80", OP_ADD, 8'h80, 8'h80, 8'h00, 1'b0, 3'b111, 1,
                  8'h00, 8'h7F, 8'h80, 3'b101, 1'b0, 1});
        lat_cfg = 10;
        start_op(OP_DIV, 8'h64, 8'h05, 8'h00, 1'b1, 3'b111);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("async_reset_outputs_zero",
              {req_ready, alu_valid, res_valid, res_err, psw_cy, psw_ac, psw_ov, alu_cy, alu_ac,
               alu_bit, alu_op, alu_src1, alu_src2, alu_src3, res_acc, res_des1, res_des2},
              {10'd0, 4'd0, 48'd0});
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("req_ready_after_midexec_reset", {31'd0, req_ready}, 32'd1);
        bad = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (res_valid || alu_valid || psw_cy || psw_ov) bad = 1'b1;
        end
        check("no_result_after_reset", {31'd0, bad}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
